sobel_gradient: RTL and testbench
=================================

// Module: sobel_gradient
// PURPOSE
//  Sobel stage downstream of buf_gauss_to_sobel. Consumes the 8 neighbours of each
//  3x3 window (centre unused) on every cycle ready is high. Produces gradient
//  magnitude and quantised direction for non-maximum suppression.
//  Streaming, 3-stage pipeline, no backpressure. Tracks output position, flags end of line/frame.
// PARAMETERS
//  WIDTH      508  input image width in pixels
//  HEIGHT     508  input image height in pixels
//  R_KERNEL   1    kernel radius; output frame is (WIDTH-2*R_KERNEL) x (HEIGHT-2*R_KERNEL)
//  MAG_SHIFT  2    right shift applied to |Gx|+|Gy| before 8-bit saturation
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   window valid (driven by upstream ready)
//  p0..p3     in   8   window row0 col0..2, row1 col0 (unsigned)
//  p5..p8     in   8   window row1 col2, row2 col0..2 (unsigned)
//  mag        out  8   gradient magnitude, saturated
//  dir        out  2   0=0deg 1=45deg 2=90deg 3=135deg
//  out_valid  out  1   mag/dir valid this cycle
//  eol        out  1   high with last output pixel of a row
//  frame_done out  1   one-cycle pulse with last output pixel of the frame
// BEHAVIOUR
//  - Reset: mag=0, dir=0, out_valid=0, eol=0, frame_done=0. All pipeline valids and counters cleared.
//  - Reset mid-frame drops in-flight windows. The next accepted window is output pixel (0,0).
//  - Latency: exactly 3 clk from in_valid sample to out_valid. Throughput 1 window/clk.
//    Gaps in in_valid propagate as gaps in out_valid. No pixel is dropped or duplicated.
//  - Gx: S1 register colL=p0+2p3+p6 and colR=p2+2p5+p8, each 10b unsigned.
//    S2 computes Gx=colR-colL.
//  - Gy: S1 register rowT=p0+2p1+p2 and rowB=p6+2p7+p8.
//    S2 computes Gy=rowB-rowT. Gx and Gy are 11b signed, range +/-1020.
//  - S2 also registers ax=|Gx|, ay=|Gy| (10b) and sgn=(Gx<0)^(Gy<0).
//  - S3 mag: s=(ax+ay)>>MAG_SHIFT (11b); mag = (s>255) ? 255 : s[7:0].
//  - S3 dir, with full-width products and no truncation:
//    - 256*ay <= 106*ax : dir=0. This covers ax=ay=0.
//    - else 256*ay >= 618*ax : dir=2.
//    - else sgn==0 : dir=1.
//    - else : dir=3.
//  - Counters col (0..WIDTH-2*R_KERNEL-1) and row (0..HEIGHT-2*R_KERNEL-1) advance on each out_valid.
//    - col wraps to 0 at max and increments row.
//    - eol=out_valid && col==max.
//    - frame_done=eol && row==max; row then wraps to 0.
//  - eol and frame_done are never high without out_valid.
//  - Windows arriving after frame_done start the next frame at (0,0).
//  - When out_valid=0, mag and dir hold their last value.
// CONFIGURATION
//  SOBEL_DIR_EN defined: direction logic per BEHAVIOUR; dir is driven.
//  SOBEL_DIR_EN undefined:
//    - No direction comparators and no sgn register are built.
//    - dir is tied to 2'd0; mag, timing and counters are unchanged.
// TESTING
//  1 Flat window, all p=100, one in_valid pulse.
//    -> out_valid 3 clk later, mag=0, dir=0.
//  2 Vertical edge: p0,p3,p6=0; p2,p5,p8=255; rest=0.
//    -> Gx=1020, mag=255, dir=0.
//  3 Horizontal edge: p0,p1,p2=0; p6,p7,p8=40; rest=0.
//    -> Gy=160, mag=40, dir=2.
//  4 Diagonals: p5=p7=p8=200, rest 0 -> Gx=Gy=600, mag=255 (saturated), dir=1.
//    Mirror p3=p6=p7=200, rest 0 -> dir=3.
//  5 Frame: 506*506 windows with random in_valid gaps.
//    -> exactly 506*506 out_valid; eol 506 times; one frame_done, on the last output.
//  6 Assert rst for 1 clk while 2 windows are in flight.
//    -> no out_valid for them; next window reports col=0,row=0; all outputs 0 during reset.

Source files
------------

// File: rtl/sobel_gradient.sv
// Sobel gradient stage: 3-stage streaming pipeline producing saturated magnitude,
// quantised direction (only when SOBEL_DIR_EN is defined) and end-of-line/frame flags.
module sobel_gradient #(
   parameter int WIDTH     = 508,
   parameter int HEIGHT    = 508,
   parameter int R_KERNEL  = 1,
   parameter int MAG_SHIFT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] p0,
   input  logic [7:0] p1,
   input  logic [7:0] p2,
   input  logic [7:0] p3,
   input  logic [7:0] p5,
   input  logic [7:0] p6,
   input  logic [7:0] p7,
   input  logic [7:0] p8,
   output logic [7:0] mag,
   output logic [1:0] dir,
   output logic       out_valid,
   output logic       eol,
   output logic       frame_done
);
   localparam int OUT_W = WIDTH - 2 * R_KERNEL;
   localparam int OUT_H = HEIGHT - 2 * R_KERNEL;
   localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);

   // S1: weighted column and row sums, each at most 4*255 = 1020
   logic [9:0] w_col_l, w_col_r, w_row_t, w_row_b;
   assign w_col_l = {2'b00, p0} + {1'b0, p3, 1'b0} + {2'b00, p6};
   assign w_col_r = {2'b00, p2} + {1'b0, p5, 1'b0} + {2'b00, p8};
   assign w_row_t = {2'b00, p0} + {1'b0, p1, 1'b0} + {2'b00, p2};
   assign w_row_b = {2'b00, p6} + {1'b0, p7, 1'b0} + {2'b00, p8};

   logic       r_v1, r_v2, r_out_valid, r_eol, r_frame_done;
   logic [9:0] r_col_l, r_col_r, r_row_t, r_row_b;
   logic [9:0] r_ax, r_ay;
   logic [7:0] r_mag;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;

   // S2: signed gradients and their magnitudes
   logic signed [10:0] w_gx, w_gy, w_gx_neg, w_gy_neg;
   logic [9:0] w_ax, w_ay;
   assign w_gx     = $signed({1'b0, r_col_r}) - $signed({1'b0, r_col_l});
   assign w_gy     = $signed({1'b0, r_row_b}) - $signed({1'b0, r_row_t});
   assign w_gx_neg = -w_gx;
   assign w_gy_neg = -w_gy;
   assign w_ax     = w_gx[10] ? w_gx_neg[9:0] : w_gx[9:0];
   assign w_ay     = w_gy[10] ? w_gy_neg[9:0] : w_gy[9:0];

   // S3: magnitude with saturation
   logic [10:0] w_sum, w_s;
   logic [7:0]  w_mag;
   assign w_sum = {1'b0, r_ax} + {1'b0, r_ay};
   assign w_s   = w_sum >> MAG_SHIFT;
   assign w_mag = (w_s > 11'd255) ? 8'hFF : w_s[7:0];

   logic w_last_col, w_last_row;
   assign w_last_col = (r_col == COL_MAX);
   assign w_last_row = (r_row == ROW_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_out_valid  <= 1'b0;
         r_eol        <= 1'b0;
         r_frame_done <= 1'b0;
         r_col_l      <= '0;
         r_col_r      <= '0;
         r_row_t      <= '0;
         r_row_b      <= '0;
         r_ax         <= '0;
         r_ay         <= '0;
         r_mag        <= '0;
         r_col        <= '0;
         r_row        <= '0;
      end else begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_col_l <= w_col_l;
            r_col_r <= w_col_r;
            r_row_t <= w_row_t;
            r_row_b <= w_row_b;
         end
         r_v2 <= r_v1;
         if (r_v1) begin
            r_ax <= w_ax;
            r_ay <= w_ay;
         end
         r_out_valid  <= r_v2;
         r_eol        <= 1'b0;
         r_frame_done <= 1'b0;
         // counters hold the position of the pixel now entering S3
         if (r_v2) begin
            r_mag        <= w_mag;
            r_eol        <= w_last_col;
            r_frame_done <= w_last_col && w_last_row;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

`ifdef SOBEL_DIR_EN
   logic       r_sgn;
   logic [1:0] r_dir;
   logic [1:0] w_dir;
   logic [19:0] w_ay256, w_ax106, w_ax618;
   assign w_ay256 = {2'b00, r_ay, 8'h00};
   assign w_ax106 = 20'(r_ax) * 20'd106;
   assign w_ax618 = 20'(r_ax) * 20'd618;

   always_comb begin
      w_dir = 2'd0;
      if (w_ay256 <= w_ax106)      w_dir = 2'd0;
      else if (w_ay256 >= w_ax618) w_dir = 2'd2;
      else if (!r_sgn)             w_dir = 2'd1;
      else                         w_dir = 2'd3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sgn <= 1'b0;
         r_dir <= 2'd0;
      end else begin
         if (r_v1) r_sgn <= w_gx[10] ^ w_gy[10];
         if (r_v2) r_dir <= w_dir;
      end
   end
   assign dir = r_dir;
`else
   assign dir = 2'd0;
`endif

   assign mag        = r_mag;
   assign out_valid  = r_out_valid;
   assign eol        = r_eol;
   assign frame_done = r_frame_done;
endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient on a reduced 10x7 image (8x5 output frame); dir is
// expected only when SOBEL_DIR_EN is defined.
module tb_sobel_gradient;
   localparam int WIDTH  = 10;
   localparam int HEIGHT = 7;
   localparam int WO     = WIDTH - 2;
   localparam int HO     = HEIGHT - 2;
`ifdef SOBEL_DIR_EN
   localparam bit DIR_EN = 1'b1;
`else
   localparam bit DIR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] p0 = 0, p1 = 0, p2 = 0, p3 = 0, p5 = 0, p6 = 0, p7 = 0, p8 = 0;
   logic [7:0] mag;
   logic [1:0] dir;
   logic       out_valid, eol, frame_done;

   sobel_gradient #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .R_KERNEL(1), .MAG_SHIFT(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
      .mag(mag), .dir(dir), .out_valid(out_valid), .eol(eol), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pix;
      logic [7:0]  mag;
      logic [1:0]  dir;
      string       name;
   } vec_t;

   typedef struct {
      logic [7:0] mag;
      logic [1:0] dir;
      logic       eol;
      logic       fd;
      string      name;
   } exp_t;

   exp_t q[$];
   vec_t vecs[13];
   int n_tests = 0, n_fail = 0;
   int exp_col = 0, exp_row = 0;
   int n_out = 0, n_eol = 0, n_fd = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   function automatic logic [63:0] mk(input int a0, a1, a2, a3, a5, a6, a7, a8);
      return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
   endfunction

   // Arithmetic reference straight from the gradient definitions
   function automatic void model(input logic [63:0] px, output logic [7:0] m, output logic [1:0] d);
      int a0, a1, a2, a3, a5, a6, a7, a8, gx, gy, ax, ay, s;
      {a0, a1, a2, a3, a5, a6, a7, a8} = {32'(px[63:56]), 32'(px[55:48]), 32'(px[47:40]),
         32'(px[39:32]), 32'(px[31:24]), 32'(px[23:16]), 32'(px[15:8]), 32'(px[7:0])};
      gx = (a2 + 2*a5 + a8) - (a0 + 2*a3 + a6);
      gy = (a6 + 2*a7 + a8) - (a0 + 2*a1 + a2);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      s  = (ax + ay) / 4;
      m  = (s > 255) ? 8'd255 : 8'(s);
      if (256*ay <= 106*ax)      d = 2'd0;
      else if (256*ay >= 618*ax) d = 2'd2;
      else if ((gx < 0) != (gy < 0)) d = 2'd3;
      else                       d = 2'd1;
   endfunction

   // Drive one window for one cycle; returns 1 ns after the sampling edge
   task automatic send(input logic [63:0] px, input logic [7:0] m, input logic [1:0] d,
                       input string nm, input bit push);
      exp_t e;
      {p0, p1, p2, p3, p5, p6, p7, p8} = px;
      in_valid = 1'b1;
      if (push) begin
         e.mag  = m;
         e.dir  = DIR_EN ? d : 2'd0;
         e.eol  = (exp_col == WO-1);
         e.fd   = (exp_col == WO-1) && (exp_row == HO-1);
         e.name = nm;
         q.push_back(e);
         if (exp_col == WO-1) begin
            exp_col = 0;
            exp_row = (exp_row == HO-1) ? 0 : exp_row + 1;
         end else begin
            exp_col++;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_timeout", int'(q.size()), 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (!out_valid) begin
            chk("flags_without_valid", int'({eol, frame_done}), 0);
         end else if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_mag"}, int'(mag), int'(e.mag));
            chk({e.name, "_dir"}, int'(dir), int'(e.dir));
            chk({e.name, "_eol"}, int'(eol), int'(e.eol));
            chk({e.name, "_fd"},  int'(frame_done), int'(e.fd));
            n_out++;
            if (eol) n_eol++;
            if (frame_done) n_fd++;
         end
      end
   end

   initial begin
      logic [7:0] m;
      logic [1:0] d;
      logic [63:0] px;
      int nf;
      vecs[0]  = '{mk(100,100,100,100,100,100,100,100), 8'd0,   2'd0, "flat"};
      vecs[1]  = '{mk(0,0,255,0,255,0,0,255),           8'd255, 2'd0, "vedge"};
      vecs[2]  = '{mk(0,0,0,0,0,40,40,40),              8'd40,  2'd2, "hedge"};
      vecs[3]  = '{mk(0,0,0,0,200,0,200,200),           8'd255, 2'd1, "diag45"};
      vecs[4]  = '{mk(0,0,0,200,0,200,200,0),           8'd255, 2'd3, "diag135"};
      vecs[5]  = '{mk(0,10,0,0,0,0,0,0),                8'd5,   2'd2, "top_p1"};
      vecs[6]  = '{mk(0,0,8,0,0,0,0,0),                 8'd4,   2'd3, "corner_p2"};
      vecs[7]  = '{mk(0,0,0,0,128,0,53,0),              8'd90,  2'd0, "b22_equal"};
      vecs[8]  = '{mk(0,0,0,0,128,0,53,1),              8'd91,  2'd1, "b22_over"};
      vecs[9]  = '{mk(0,0,0,0,28,0,209,200),            8'd218, 2'd2, "b67_equal"};
      vecs[10] = '{mk(0,0,255,0,255,0,2,255),           8'd255, 2'd0, "sat_1024"};
      vecs[11] = '{mk(0,1,0,0,0,0,0,0),                 8'd0,   2'd2, "shift_floor"};
      vecs[12] = '{mk(0,0,0,0,255,0,0,0),               8'd127, 2'd0, "half_vedge"};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'({mag, dir, out_valid, eol, frame_done}), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single pulse: out_valid appears exactly three edges after sampling
      send(vecs[0].pix, vecs[0].mag, vecs[0].dir, vecs[0].name, 1'b1);
      @(negedge clk); chk("lat_edge1", int'(out_valid), 0);
      @(negedge clk); chk("lat_edge2", int'(out_valid), 0);
      @(negedge clk); chk("lat_edge3", int'(out_valid), 1);
      @(posedge clk); #1;

      for (int i = 1; i < 13; i++)
         send(vecs[i].pix, vecs[i].mag, vecs[i].dir, vecs[i].name, 1'b1);
      drain();

      // Reset with two windows in flight
      send(vecs[3].pix, 8'd0, 2'd0, "inflight", 1'b0);
      send(vecs[4].pix, 8'd0, 2'd0, "inflight", 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mag_in_reset", int'(mag), 0);
      chk("rst_ov_in_reset", int'(out_valid), 0);
      rst = 1'b0;
      exp_col = 0;
      exp_row = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_dropped", int'(out_valid), 0);
      end
      @(posedge clk); #1;

      // Full frame plus three windows of the next, with random gaps
      n_out = 0; n_eol = 0; n_fd = 0;
      nf = WO*HO + 3;
      for (int i = 0; i < nf; i++) begin
         px = {$urandom, $urandom};
         model(px, m, d);
         send(px, m, d, "frame", 1'b1);
         if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();
      chk("frame_out_count", n_out, nf);
      chk("frame_eol_count", n_eol, HO);
      chk("frame_done_count", n_fd, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
